fir16_axil_slave: RTL and testbench

FIR16_AXIL_SLAVE -- requirements
Module: fir16_axil_slave

---
 rtl/fir16_axil_pkg.sv | 29 ++
 rtl/fir16_coef_bank.sv | 39 +++
 rtl/fir16_axil_slave.sv | 111 +++++++++++
 tb/tb_fir16_axil_slave.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir16_axil_pkg.sv
// fir16_axil_pkg: register map, response codes and decode helpers for the FIR16 AXI-Lite slave
package fir16_axil_pkg;
  localparam int NUM_COEF = 16;
  localparam int COEF_W = 16;
  localparam int COMMIT_BIT = 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [6:0] OFF_CTRL = 7'h00;
  localparam logic [6:0] OFF_SCRATCH0 = 7'h04;
  localparam logic [6:0] OFF_SCRATCH1 = 7'h08;
  localparam logic [6:0] OFF_SCRATCH2 = 7'h0C;
  localparam logic [6:0] OFF_STATUS = 7'h10;
  localparam logic [6:0] OFF_COEF0 = 7'h40;
  localparam logic [31:0] CTRL_WMASK = ~(32'd1 << COMMIT_BIT);
  typedef enum logic [2:0] {R_CTRL, R_SCR, R_STATUS, R_COEF, R_NONE} region_t;
  function automatic region_t decode(input logic [6:0] a);
    logic [4:0] w;
    w = a[6:2];
    return a >= OFF_COEF0 ? R_COEF :
           w == OFF_CTRL[6:2] ? R_CTRL :
           w <= OFF_SCRATCH2[6:2] ? R_SCR :
           w == OFF_STATUS[6:2] ? R_STATUS : R_NONE;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? din[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/fir16_coef_bank.sv
// fir16_coef_bank: shadow/active coefficient banks with atomic commit, dirty flag and commit counter
module fir16_coef_bank
  import fir16_axil_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       wr_en_i,
  input  logic [3:0]                 wr_idx_i,
  input  logic [COEF_W-1:0]          wr_data_i,
  input  logic                       commit_i,
  output logic [NUM_COEF*COEF_W-1:0] shadow_o,
  output logic [NUM_COEF*COEF_W-1:0] coef_o,
  output logic                       coef_load_o,
  output logic                       dirty_o,
  output logic [15:0]                count_o
);
  logic [NUM_COEF*COEF_W-1:0] shadow_q, active_q;
  logic load_q;
  logic [15:0] count_q;
  // Whole-vector copy keeps the active bank update atomic.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shadow_q <= '0;
      active_q <= '0;
      load_q <= 1'b0;
      count_q <= '0;
    end else begin
      load_q <= commit_i;
      if (commit_i) active_q <= shadow_q;
      if (commit_i) count_q <= count_q + 16'd1;
      if (wr_en_i) shadow_q[{wr_idx_i, 4'b0} +: COEF_W] <= wr_data_i;
    end
  end
  assign shadow_o = shadow_q;
  assign coef_o = active_q;
  assign coef_load_o = load_q;
  assign dirty_o = shadow_q != active_q;
  assign count_o = count_q;
endmodule

// File: rtl/fir16_axil_slave.sv
// fir16_axil_slave: AXI4-Lite register slave with double-buffered FIR coefficient bank
module fir16_axil_slave
  import fir16_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_COEF*COEF_W-1:0]      coef_o,
  output logic                            coef_load_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_o
);
  logic aw_q, aw_d, ar_q, ar_d, bv_q, bv_d, rv_q, rv_d;
  logic [1:0] br_q, br_d, rr_q, rr_d;
  logic [31:0] rd_q, rd_d, old_w, new_w;
  logic [31:0] regs_q [4];
  logic [31:0] regs_d [4];
  logic [NUM_COEF*COEF_W-1:0] shadow;
  logic [15:0] count;
  logic dirty, wr_fire, rd_fire, wr_ok, coef_wr, commit, unused_ok;
  region_t wr_rg, rd_rg;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot};
  assign wr_rg = decode(s00_axi_awaddr);
  assign rd_rg = decode(s00_axi_araddr);
  assign wr_fire = aw_q && s00_axi_awvalid && s00_axi_wvalid;
  assign rd_fire = ar_q && s00_axi_arvalid;
  assign wr_ok = wr_rg inside {R_CTRL, R_SCR, R_COEF};
  assign old_w = wr_rg == R_COEF ? {16'b0, shadow[{s00_axi_awaddr[5:2], 4'b0} +: COEF_W]} : regs_q[s00_axi_awaddr[3:2]];
  assign new_w = merge(old_w, s00_axi_wdata, s00_axi_wstrb);
  assign coef_wr = wr_fire && wr_rg == R_COEF;
  assign commit = wr_fire && wr_rg == R_CTRL && new_w[COMMIT_BIT];
  // Read data is captured from pre-edge state, so a same-cycle write to the same address is not visible.
  always_comb begin
    aw_d = !aw_q && s00_axi_awvalid && s00_axi_wvalid && !bv_q;
    ar_d = !ar_q && s00_axi_arvalid && !rv_q;
    bv_d = wr_fire || (bv_q && !s00_axi_bready);
    br_d = wr_fire ? (wr_ok ? RESP_OKAY : RESP_SLVERR) : br_q;
    rv_d = rd_fire || (rv_q && !s00_axi_rready);
    rr_d = rd_fire ? (rd_rg == R_NONE ? RESP_SLVERR : RESP_OKAY) : rr_q;
    rd_d = !rd_fire ? rd_q :
           rd_rg inside {R_CTRL, R_SCR} ? regs_q[s00_axi_araddr[3:2]] :
           rd_rg == R_STATUS ? {15'b0, dirty, count} :
           rd_rg == R_COEF ? {16'b0, shadow[{s00_axi_araddr[5:2], 4'b0} +: COEF_W]} : '0;
    regs_d = regs_q;
    if (wr_fire && wr_rg inside {R_CTRL, R_SCR})
      regs_d[s00_axi_awaddr[3:2]] = wr_rg == R_CTRL ? new_w & CTRL_WMASK : new_w;
  end
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      aw_q <= 1'b0;
      ar_q <= 1'b0;
      bv_q <= 1'b0;
      rv_q <= 1'b0;
      br_q <= RESP_OKAY;
      rr_q <= RESP_OKAY;
      rd_q <= '0;
      regs_q <= '{default: '0};
    end else begin
      aw_q <= aw_d;
      ar_q <= ar_d;
      bv_q <= bv_d;
      rv_q <= rv_d;
      br_q <= br_d;
      rr_q <= rr_d;
      rd_q <= rd_d;
      regs_q <= regs_d;
    end
  end
  fir16_coef_bank u_bank (
    .clk_i       (s00_axi_aclk),
    .rst_n_i     (s00_axi_aresetn),
    .wr_en_i     (coef_wr),
    .wr_idx_i    (s00_axi_awaddr[5:2]),
    .wr_data_i   (new_w[COEF_W-1:0]),
    .commit_i    (commit),
    .shadow_o    (shadow),
    .coef_o      (coef_o),
    .coef_load_o (coef_load_o),
    .dirty_o     (dirty),
    .count_o     (count)
  );
  assign s00_axi_awready = aw_q;
  assign s00_axi_wready = aw_q;
  assign s00_axi_bvalid = bv_q;
  assign s00_axi_bresp = br_q;
  assign s00_axi_arready = ar_q;
  assign s00_axi_rvalid = rv_q;
  assign s00_axi_rresp = rr_q;
  assign s00_axi_rdata = rd_q;
  assign ctrl_o = regs_q[0];
endmodule

// File: tb/tb_fir16_axil_slave.sv
// tb_fir16_axil_slave: directed and randomized checks of fir16_axil_slave against a register-map model
module tb_fir16_axil_slave;
  logic clk = 0, rstn = 0;
  logic [6:0] awaddr = 0, araddr = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid, coef_load;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, ctrl;
  logic [255:0] coef;
  int checks = 0, errors = 0;
  logic [31:0] m_regs [4];
  logic [15:0] m_sh [16];
  logic [15:0] m_act [16];
  int m_cnt;

  fir16_axil_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .coef_o(coef), .coef_load_o(coef_load), .ctrl_o(ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  function automatic logic [255:0] m_coef();
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = m_act[k];
    return r;
  endfunction

  function automatic logic [31:0] m_status();
    logic dirty;
    dirty = 0;
    for (int k = 0; k < 16; k++) if (m_sh[k] != m_act[k]) dirty = 1;
    return {15'b0, dirty, 16'(m_cnt % 65536)};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    for (int k = 0; k < 16; k++) begin m_sh[k] = 0; m_act[k] = 0; end
    m_cnt = 0;
  endtask

  task automatic m_write(input int a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    logic [31:0] v;
    resp = 2'b00;
    if (a >= 'h40) begin
      v = bmerge({16'b0, m_sh[(a - 'h40) / 4]}, d, s);
      m_sh[(a - 'h40) / 4] = v[15:0];
    end else if (a < 'h10) begin
      v = bmerge(m_regs[a / 4], d, s);
      if (a == 0 && v[1]) begin
        for (int k = 0; k < 16; k++) m_act[k] = m_sh[k];
        m_cnt++;
        v[1] = 0;
      end
      m_regs[a / 4] = v;
    end else resp = 2'b10;
  endtask

  task automatic m_read(input int a, output logic [31:0] d, output logic [1:0] resp);
    resp = 2'b00;
    if (a >= 'h40) d = {16'b0, m_sh[(a - 'h40) / 4]};
    else if (a < 'h10) d = m_regs[a / 4];
    else if (a == 'h10) d = m_status();
    else begin d = 0; resp = 2'b10; end
  endtask

  task automatic axi_write(input int a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp, output logic ld);
    int n;
    @(negedge clk);
    awaddr = 7'(a); wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("awready_seen", awready, 1'b1);
    @(negedge clk);
    awvalid = 0; wvalid = 0; ld = coef_load;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid_seen", bvalid, 1'b1);
    resp = bresp;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input int a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = 7'(a); arvalid = 1; rready = 1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("arready_seen", arready, 1'b1);
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rvalid_seen", rvalid, 1'b1);
    d = rdata; resp = rresp;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic wr_chk(input int a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r, er;
    logic ld;
    axi_write(a, d, s, r, ld);
    m_write(a, d, s, er);
    chk("bresp", r, er);
  endtask

  task automatic rd_chk(input int a, output logic [31:0] d);
    logic [31:0] ed;
    logic [1:0] r, er;
    m_read(a, ed, er);
    axi_read(a, d, r);
    chk("rdata", d, ed);
    chk("rresp", r, er);
  endtask

  initial begin
    logic [31:0] d, ed;
    logic [1:0] r, er;
    logic ld;
    int a;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_valid_ready", {awready, wready, arready, bvalid, rvalid}, 0);
    chk("reset_resp_rdata", {bresp, rresp, rdata}, 0);
    chk("reset_coef", coef, 0);
    chk("reset_ctrl_load", {ctrl, coef_load}, 0);
    rstn = 1;
    rd_chk('h10, d);
    chk("status_reset", d, 32'h0);
    // coefficient staging and commit
    wr_chk('h4C, 32'h0000_1234, 4'hF);
    chk("coef_unchanged", coef, 0);
    rd_chk('h10, d);
    chk("status_dirty", d, 32'h0001_0000);
    axi_write('h00, 32'h2, 4'hF, r, ld);
    m_write('h00, 32'h2, 4'hF, er);
    chk("commit_bresp", r, 2'b00);
    chk("commit_load_pulse", ld, 1'b1);
    chk("commit_load_single", coef_load, 1'b0);
    chk("coef3_active", coef[63:48], 16'h1234);
    chk("coef_model", coef, m_coef());
    rd_chk('h10, d);
    chk("status_commit", d, 32'h0000_0001);
    // plain registers
    wr_chk('h00, 32'h0101_FFFF, 4'hF);
    wr_chk('h04, 32'hABCD_0001, 4'hF);
    wr_chk('h08, 32'hDEAD_0011, 4'hF);
    wr_chk('h0C, 32'hBEEF_0011, 4'hF);
    rd_chk('h00, d);
    chk("ctrl_read", d, 32'h0101_FFFD);
    chk("ctrl_o", ctrl, 32'h0101_FFFD);
    rd_chk('h04, d);
    rd_chk('h08, d);
    rd_chk('h0C, d);
    chk("scratch2_read", d, 32'hBEEF_0011);
    // byte strobes
    wr_chk('h04, 32'h0, 4'hF);
    wr_chk('h04, 32'hFFFF_FFFF, 4'b0101);
    rd_chk('h04, d);
    chk("strobe_read", d, 32'h00FF_00FF);
    // unmapped and read-only
    rd_chk('h20, d);
    chk("unmapped_rdata", d, 32'h0);
    wr_chk('h30, 32'hFFFF_FFFF, 4'hF);
    wr_chk('h10, 32'hFFFF_FFFF, 4'hF);
    rd_chk('h10, d);
    rd_chk('h04, d);
    // simultaneous read and write to one address
    m_read('h0C, ed, er);
    @(negedge clk);
    awaddr = 7'h0C; araddr = 7'h0C; wdata = 32'hC0FF_EE00; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    @(negedge clk);
    chk("sim_awready", awready, 1'b1);
    chk("sim_arready", arready, 1'b1);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("sim_valids", {bvalid, rvalid}, 2'b11);
    chk("sim_old_rdata", rdata, ed);
    m_write('h0C, 32'hC0FF_EE00, 4'hF, er);
    @(negedge clk);
    bready = 0; rready = 0;
    rd_chk('h0C, d);
    // address ahead of data, slow response consumer
    @(negedge clk);
    awaddr = 7'h08; wdata = 32'h5A5A_1234; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("aw_held_off", {awready, wready}, 2'b00);
    end
    wvalid = 1;
    for (int n = 0; n < 20 && !awready; n++) @(negedge clk);
    chk("aw_with_w", {awready, wready}, 2'b11);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    m_write('h08, 32'h5A5A_1234, 4'hF, er);
    for (int i = 0; i < 5; i++) begin
      chk("bvalid_held", bvalid, 1'b1);
      chk("no_second_accept", awready, 1'b0);
      if (i == 0) begin wdata = 32'h1111_1111; awvalid = 1; wvalid = 1; end
      @(negedge clk);
    end
    awvalid = 0; wvalid = 0; bready = 1;
    chk("held_bresp", bresp, 2'b00);
    @(negedge clk);
    chk("bvalid_cleared", bvalid, 1'b0);
    bready = 0;
    rd_chk('h08, d);
    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a = sel < 6 ? 'h40 + 4 * $urandom_range(0, 15) : sel < 8 ? 4 * $urandom_range(0, 4) : 'h14 + 4 * $urandom_range(0, 10);
      if ($urandom_range(0, 2) == 0) rd_chk(a, d);
      else wr_chk(a, $urandom, 4'($urandom_range(0, 15)));
      chk("rand_coef", coef, m_coef());
      chk("rand_ctrl", ctrl, m_regs[0]);
    end
    rd_chk('h10, d);
    // reset while a read response is pending
    wr_chk('h40, 32'h0000_BEEF, 4'hF);
    wr_chk('h00, 32'h2, 4'h1);
    chk("pre_reset_coef", coef, m_coef());
    @(negedge clk);
    araddr = 7'h40; arvalid = 1; rready = 0;
    for (int n = 0; n < 20 && !arready; n++) @(negedge clk);
    chk("pre_reset_arready", arready, 1'b1);
    @(negedge clk);
    arvalid = 0;
    chk("pre_reset_rvalid", rvalid, 1'b1);
    rstn = 0;
    @(negedge clk);
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_coef_mid", coef, 0);
    chk("reset_rdata_mid", rdata, 0);
    rstn = 1;
    m_reset();
    rd_chk('h10, d);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
